// File: rtl/ysyx_24110015_mem_arb_pkg.sv
// Shared encodings and defaults for the IFU/LSU pmem arbiter.
// Owner encoding doubles as the round-robin priority value.
package ysyx_24110015_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } arb_state_e;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 256;
  localparam logic [31:0] DEF_ERR_RDATA      = 32'hDEAD_BEEF;

endpackage

// File: rtl/ysyx_24110015_rr_arb2.sv
// Two-way combinational pick: a lone requester always wins, a tie goes to the side named by prio.
// Bit 0 is IFU, bit 1 is LSU.
module ysyx_24110015_rr_arb2
  import ysyx_24110015_mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = (prio == OWN_LSU) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ysyx_24110015_mem_arb.sv
// Serialises IFU and LSU accesses onto the single pmem adapter port, one transaction in flight,
// round-robin grant, and synthesises an error response when memory stalls past the timeout.
module ysyx_24110015_mem_arb
  import ysyx_24110015_mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [31:0] ERR_RDATA      = DEF_ERR_RDATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_rdata,
  output logic        ifu_resp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_rdata,
  output logic        lsu_resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  output logic        mem_resp_ready,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  arb_state_e    state_q, state_d;
  logic          owner_q, owner_d;
  logic          prio_q, prio_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic          wen_q, wen_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wmask_q, wmask_d;

  logic [1:0]    grant;
  logic          timed_out;
  logic          own_resp_ready;
  logic [31:0]   rsp_data;

  ysyx_24110015_rr_arb2 u_pick (
    .valid ({lsu_req_valid, ifu_req_valid}),
    .prio  (prio_q),
    .grant (grant)
  );

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IFU;
      prio_q  <= OWN_IFU;
      cnt_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;

    ifu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    ifu_resp_err   = 1'b0;
    lsu_req_ready  = 1'b0;
    lsu_resp_valid = 1'b0;
    lsu_rdata      = '0;
    lsu_resp_err   = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;

    timed_out      = (cnt_q == CNT_LAST);
    own_resp_ready = (owner_q == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;
    rsp_data       = wen_q ? 32'h0 : mem_rdata;

    unique case (state_q)
      ST_IDLE: begin
        // Strays left over from an aborted transaction are swallowed here.
        mem_resp_ready = 1'b1;
        ifu_req_ready  = grant[0];
        lsu_req_ready  = grant[1];
        if (grant[0]) begin
          owner_d = OWN_IFU;
          prio_d  = OWN_LSU;
          addr_d  = ifu_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          cnt_d   = '0;
          state_d = ST_REQ;
        end else if (grant[1]) begin
          owner_d = OWN_LSU;
          prio_d  = OWN_IFU;
          addr_d  = lsu_addr;
          wen_d   = lsu_wen;
          wdata_d = lsu_wdata;
          wmask_d = lsu_wmask;
          cnt_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        cnt_d         = cnt_q + CW'(1);
        if (mem_req_ready) state_d = ST_RESP;
        else if (timed_out) state_d = ST_ERR;
      end
      ST_RESP: begin
        mem_resp_ready = own_resp_ready;
        cnt_d          = cnt_q + CW'(1);
        if (owner_q == OWN_LSU) begin
          lsu_resp_valid = mem_resp_valid;
          lsu_rdata      = rsp_data;
        end else begin
          ifu_resp_valid = mem_resp_valid;
          ifu_rdata      = rsp_data;
        end
        // A response landing on the last cycle still wins over the abort.
        if (mem_resp_valid && own_resp_ready) state_d = ST_IDLE;
        else if (timed_out) state_d = ST_ERR;
      end
      ST_ERR: begin
        if (owner_q == OWN_LSU) begin
          lsu_resp_valid = 1'b1;
          lsu_resp_err   = 1'b1;
          lsu_rdata      = ERR_RDATA;
        end else begin
          ifu_resp_valid = 1'b1;
          ifu_resp_err   = 1'b1;
          ifu_rdata      = ERR_RDATA;
        end
        if (own_resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // While reset is held nothing may handshake or be delivered, whatever state we came from.
    if (!rst) begin
      ifu_req_ready  = 1'b0;
      ifu_resp_valid = 1'b0;
      ifu_rdata      = '0;
      ifu_resp_err   = 1'b0;
      lsu_req_ready  = 1'b0;
      lsu_resp_valid = 1'b0;
      lsu_rdata      = '0;
      lsu_resp_err   = 1'b0;
      mem_req_valid  = 1'b0;
      mem_resp_ready = 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_24110015_mem_arb.sv
// Directed bench for the IFU/LSU pmem arbiter: transaction table plus hand-written corner sequences.
module tb_ysyx_24110015_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_24110015_mem_arb #(.TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        lsu;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          req_wait;
    int          resp_wait;
    logic [31:0] mem_data;
    logic        exp_wen;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns one time unit after the next rising edge: the drive point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 0; ifu_addr = '0; ifu_resp_ready = 0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0; lsu_resp_ready = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
  endtask

  task automatic run_txn(input vec_t v);
    idle_inputs();
    ifu_req_valid = !v.lsu;
    lsu_req_valid = v.lsu;
    ifu_addr  = v.addr;
    lsu_addr  = v.addr;
    lsu_wen   = v.wen;
    lsu_wdata = v.wdata;
    lsu_wmask = v.wmask;
    mem_rdata = v.mem_data;
    #1;
    chk("txn_req_ready", v.lsu ? lsu_req_ready : ifu_req_ready, 1);
    chk("txn_loser_ready", v.lsu ? ifu_req_ready : lsu_req_ready, 0);
    tick();
    ifu_req_valid = 0;
    lsu_req_valid = 0;
    for (int c = 0; c <= v.req_wait; c++) begin
      mem_req_ready = (c == v.req_wait);
      #1;
      chk("txn_mem_req_valid", mem_req_valid, 1);
      chk("txn_mem_addr", mem_addr, v.addr);
      chk("txn_mem_wen", mem_wen, v.exp_wen);
      chk("txn_mem_wdata", mem_wdata, v.exp_wdata);
      chk("txn_mem_wmask", mem_wmask, v.exp_wmask);
      chk("txn_no_resp_in_req", ifu_resp_valid | lsu_resp_valid, 0);
      tick();
    end
    mem_req_ready = 0;
    for (int c = 0; c < v.resp_wait; c++) begin
      #1;
      chk("txn_resp_wait_valid", ifu_resp_valid | lsu_resp_valid, 0);
      chk("txn_resp_wait_req", mem_req_valid, 0);
      tick();
    end
    mem_resp_valid = 1;
    ifu_resp_ready = 1;
    lsu_resp_ready = 1;
    #1;
    chk("txn_resp_valid", v.lsu ? lsu_resp_valid : ifu_resp_valid, 1);
    chk("txn_other_resp_valid", v.lsu ? ifu_resp_valid : lsu_resp_valid, 0);
    chk("txn_rdata", v.lsu ? lsu_rdata : ifu_rdata, v.exp_rdata);
    chk("txn_err", ifu_resp_err | lsu_resp_err, 0);
    chk("txn_mem_resp_ready", mem_resp_ready, 1);
    tick();
    idle_inputs();
    #1;
    chk("txn_after_resp_valid", ifu_resp_valid | lsu_resp_valid, 0);
    chk("txn_after_req_valid", mem_req_valid, 0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        lsu addr          wen wdata         wmask    rw rs mem_data        ewen ewdata       ewmask   erdata
    vecs[0] = '{1'b0, 32'h8000_0000, 1'b1, 32'hCAFE_F00D, 4'b1111, 1, 2, 32'h0000_0413, 1'b0, 32'h0,        4'b0000, 32'h0000_0413};
    vecs[1] = '{1'b1, 32'h8000_1000, 1'b1, 32'h1234_5678, 4'b0011, 3, 0, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678, 4'b0011, 32'h0};
    vecs[2] = '{1'b1, 32'h8000_2004, 1'b0, 32'h55AA_55AA, 4'b1111, 0, 0, 32'h0BAD_F00D, 1'b0, 32'h55AA_55AA, 4'b1111, 32'h0BAD_F00D};
    vecs[3] = '{1'b0, 32'h8000_0004, 1'b0, 32'h0,         4'b0000, 0, 4, 32'h0010_0073, 1'b0, 32'h0,        4'b0000, 32'h0010_0073};
    vecs[4] = '{1'b1, 32'h8000_3000, 1'b1, 32'hA1B2_C3D4, 4'b1000, 2, 3, 32'h1111_1111, 1'b1, 32'hA1B2_C3D4, 4'b1000, 32'h0};

    // Reset held two cycles with both masters requesting.
    idle_inputs();
    rst = 0;
    ifu_req_valid = 1;
    lsu_req_valid = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_ifu_req_ready", ifu_req_ready, 0);
    chk("rst_lsu_req_ready", lsu_req_ready, 0);
    chk("rst_ifu_resp_valid", ifu_resp_valid, 0);
    chk("rst_lsu_resp_valid", lsu_resp_valid, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_resp_ready", mem_resp_ready, 1);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_errs", {ifu_resp_err, lsu_resp_err}, 0);
    chk("rst_rdata_or", ifu_rdata | lsu_rdata, 0);
    rst = 1;
    ifu_req_valid = 0;
    lsu_req_valid = 0;
    tick();

    // Both masters request continuously: grants must alternate starting at IFU.
    ifu_req_valid = 1; ifu_addr = 32'h8000_0100; ifu_resp_ready = 1;
    lsu_req_valid = 1; lsu_addr = 32'h8000_0200; lsu_wen = 0; lsu_resp_ready = 1;
    mem_req_ready = 1; mem_resp_valid = 1;
    for (int k = 0; k < 6; k++) begin
      mem_rdata = 32'h5A5A_0000 | k;
      #1;
      chk("rr_grant_ifu", ifu_req_ready, (k % 2) == 0);
      chk("rr_grant_lsu", lsu_req_ready, (k % 2) == 1);
      tick();
      #1;
      chk("rr_req_busy_ready", ifu_req_ready | lsu_req_ready, 0);
      chk("rr_req_valid", mem_req_valid, 1);
      chk("rr_req_addr", mem_addr, (k % 2) ? 32'h8000_0200 : 32'h8000_0100);
      tick();
      #1;
      chk("rr_resp_busy_ready", ifu_req_ready | lsu_req_ready, 0);
      chk("rr_resp_ifu", ifu_resp_valid, (k % 2) == 0);
      chk("rr_resp_lsu", lsu_resp_valid, (k % 2) == 1);
      chk("rr_resp_data", (k % 2) ? lsu_rdata : ifu_rdata, 32'h5A5A_0000 | k);
      tick();
    end
    idle_inputs();
    tick();

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // LSU read that memory never accepts: error after 8 cycles in REQ.
    lsu_req_valid = 1; lsu_addr = 32'h8000_4000; lsu_wen = 0;
    #1;
    chk("to_req_ready", lsu_req_ready, 1);
    tick();
    lsu_req_valid = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("to_pending_req_valid", mem_req_valid, 1);
      chk("to_pending_resp_valid", lsu_resp_valid, 0);
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("to_err_valid", lsu_resp_valid, 1);
      chk("to_err_flag", lsu_resp_err, 1);
      chk("to_err_rdata", lsu_rdata, 32'hDEAD_BEEF);
      chk("to_err_req_dropped", mem_req_valid, 0);
      chk("to_err_ifu_quiet", ifu_resp_valid, 0);
      tick();
    end
    lsu_resp_ready = 1;
    #1;
    chk("to_err_taken", lsu_resp_valid, 1);
    tick();
    lsu_resp_ready = 1;
    mem_resp_valid = 1;
    mem_rdata = 32'h7777_7777;
    #1;
    chk("late_mem_resp_ready", mem_resp_ready, 1);
    chk("late_lsu_resp_valid", lsu_resp_valid, 0);
    chk("late_ifu_resp_valid", ifu_resp_valid, 0);
    tick();
    idle_inputs();
    #1;
    chk("late_dropped_lsu", lsu_resp_valid, 0);
    tick();

    // Reset while IFU response is pending and stalled by the IFU.
    ifu_req_valid = 1; ifu_addr = 32'h8000_0008;
    mem_req_ready = 1;
    #1;
    chk("rr_ifu_grant_pre_rst", ifu_req_ready, 1);
    tick();
    ifu_req_valid = 0;
    tick();
    mem_req_ready = 0;
    mem_resp_valid = 1;
    mem_rdata = 32'h0000_0013;
    #1;
    chk("rst_resp_pending", ifu_resp_valid, 1);
    rst = 0;
    #1;
    chk("rst_resp_suppressed", ifu_resp_valid, 0);
    tick();
    rst = 1;
    mem_resp_valid = 0;
    ifu_resp_ready = 1;
    #1;
    chk("rst_after_no_resp", ifu_resp_valid, 0);
    ifu_req_valid = 1;
    lsu_req_valid = 1;
    #1;
    chk("rst_after_grant_ifu", ifu_req_ready, 1);
    chk("rst_after_grant_lsu", lsu_req_ready, 0);
    tick();
    idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
